// File: rtl/k_cplx_sample_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k_aud_cmprs_pkg
// Brief    : Shared states and width constants for the audio compressor
//            complex-sample transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package k_aud_cmprs_pkg;

  // Default component width and frame length of the FFT bin stream
  localparam int unsigned c_in_width  = 16;
  localparam int unsigned c_frame_len = 64;

  // Transmit frame states: collect, prime output register, stream out
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } tx_state_t;

  // A complex word carries re and im side by side
  function automatic int unsigned cplx_word_w(input int unsigned comp_w);
    return 2 * comp_w;
  endfunction

endpackage : k_aud_cmprs_pkg
`default_nettype wire

// File: rtl/k_cplx_sample_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : k_cplx_sample_tx_if
// Brief    : AXI-Stream link carrying {re,im} complex words.
// Revision : 1.0 - initial release
// ============================================================================
interface k_cplx_sample_tx_if
  import k_aud_cmprs_pkg::*;
#(
  parameter int DATA_W = cplx_word_w(c_in_width)
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface : k_cplx_sample_tx_if
`default_nettype wire

// File: rtl/k_cplx_frame_ram.sv
`default_nettype none
// ============================================================================
// Module   : k_cplx_frame_ram
// Brief    : Single-frame sample store, one write port and one synchronous
//            read port, written so that it maps onto BRAM or LUTRAM.
// Revision : 1.0 - initial release
// ============================================================================
module k_cplx_frame_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write and registered read; contents need no reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule : k_cplx_frame_ram
`default_nettype wire

// File: rtl/k_cplx_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : k_cplx_sample_tx
// Brief    : Buffers one frame of complex samples from a write port, then
//            streams it out in write order as an AXI-Stream master.
//            Optional macro K_CPLX_TX_TLAST_EN enables m_axis.tlast on the
//            final beat of each frame; otherwise tlast is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module k_cplx_sample_tx
  import k_aud_cmprs_pkg::*;
#(
  parameter  int IN_WIDTH  = c_in_width,
  parameter  int FRAME_LEN = c_frame_len,
  localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  wire logic                clk,
  input  wire logic                resetn,
  input  wire logic                wr_en,
  input  wire logic [IN_WIDTH-1:0] wr_re,
  input  wire logic [IN_WIDTH-1:0] wr_im,
  output logic                     wr_ready,
  output logic                     frame_done,
  k_cplx_sample_tx_if.master       m_axis
);

  localparam int              c_data_w = cplx_word_w(IN_WIDTH);
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(FRAME_LEN - 1);

  tx_state_t           r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_wr_ready;
  logic                r_tvalid;
  logic [c_data_w-1:0] r_tdata;
  logic                r_frame_done;
  logic                w_wr_acc;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [c_data_w-1:0] w_rd_data;
`ifdef K_CPLX_TX_TLAST_EN
  logic                r_tlast;
`endif

  assign w_wr_acc = wr_en & r_wr_ready & (r_state == FILL);
  assign w_hs     = r_tvalid & m_axis.tready;

  // Read address runs one ahead so the RAM output already holds buf[rd_ptr]
  always_comb begin
    w_rd_addr = r_rd_ptr;
    if (r_state == LOAD) begin
      w_rd_addr = ADDR_W'(1);
    end else if ((r_state == STREAM) && w_hs) begin
      w_rd_addr = r_rd_ptr + ADDR_W'(1);
    end
  end

  k_cplx_frame_ram #(
    .DATA_W (c_data_w),
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata ({wr_re, wr_im}),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  // Frame FSM with pointers and the registered AXIS output stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wr_ready   <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_frame_done <= 1'b0;
`ifdef K_CPLX_TX_TLAST_EN
      r_tlast      <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FILL: begin
          r_wr_ready <= 1'b1;
          if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (r_wr_ptr == c_last) begin
              r_wr_ready <= 1'b0;
              r_state    <= LOAD;
            end
          end
        end
        LOAD: begin
          r_tdata  <= w_rd_data;
          r_tvalid <= 1'b1;
          r_rd_ptr <= ADDR_W'(1);
          r_state  <= STREAM;
`ifdef K_CPLX_TX_TLAST_EN
          r_tlast  <= 1'b0;
`endif
        end
        STREAM: begin
          if (w_hs) begin
            if (r_rd_ptr == '0) begin
              // Final beat accepted: hand the buffer back to the writer
              r_tvalid     <= 1'b0;
              r_frame_done <= 1'b1;
              r_wr_ready   <= 1'b1;
              r_state      <= FILL;
`ifdef K_CPLX_TX_TLAST_EN
              r_tlast      <= 1'b0;
`endif
            end else begin
              r_tdata  <= w_rd_data;
              r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
`ifdef K_CPLX_TX_TLAST_EN
              r_tlast  <= (r_rd_ptr == c_last);
`endif
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign wr_ready      = r_wr_ready;
  assign frame_done    = r_frame_done;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
`ifdef K_CPLX_TX_TLAST_EN
  assign m_axis.tlast  = r_tlast;
`else
  assign m_axis.tlast  = 1'b0;
`endif

endmodule : k_cplx_sample_tx
`default_nettype wire

// File: tb/tb_k_cplx_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_cplx_sample_tx
// Brief    : Directed self-checking bench for k_cplx_sample_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k_cplx_sample_tx;

`ifdef K_CPLX_TX_TLAST_EN
  localparam bit c_tlast_en = 1'b1;
`else
  localparam bit c_tlast_en = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic [15:0] wr_re;
  logic [15:0] wr_im;
  logic        wr_ready;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdat    [64];
  logic [31:0] rx_data [64];
  logic        rx_last [64];
  int          n_rx;
  bit          pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  k_cplx_sample_tx_if #(.DATA_W(32)) axis ();

  k_cplx_sample_tx #(
    .IN_WIDTH  (16),
    .FRAME_LEN (64)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_re      (wr_re),
    .wr_im      (wr_im),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .m_axis     (axis)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Writes wdat[0..63] back-to-back; returns at the negedge after the last write
  task automatic write_frame();
    int t = 0;
    while (wr_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_timeout: wr_ready=%b required 1", wr_ready);
    end
    for (int k = 0; k < 64; k++) begin
      wr_en = 1'b1;
      {wr_re, wr_im} = wdat[k];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Drives tready (mode 0: always 1, mode 1: 1,0,0,1) and records beats
  task automatic capture(input int mode, input int max_beats,
                         output int cycles, output int viol);
    logic [31:0] pd;
    bit          pstall;
    n_rx = 0; cycles = 0; viol = 0; pstall = 1'b0; pd = '0;
    while (n_rx < max_beats && cycles < 400) begin
      axis.tready = (mode == 0) ? 1'b1 : pattern[cycles % 4];
      if (axis.tvalid !== 1'b1) viol++;
      if (pstall && axis.tdata !== pd) viol++;
      if (axis.tvalid === 1'b1 && axis.tready) begin
        rx_data[n_rx] = axis.tdata;
        rx_last[n_rx] = axis.tlast;
        n_rx++;
        if (n_rx == max_beats) wr_en = 1'b0;
      end
      pstall = (axis.tvalid === 1'b1) && !axis.tready;
      pd     = axis.tdata;
      cycles++;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 32'h0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h wr_ready=%b required 0/00000000/0",
               axis.tvalid, axis.tdata, wr_ready);
    end
    checks++;
    if (frame_done !== 1'b0 || axis.tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: frame_done=%b tlast=%b required 0/0", frame_done, axis.tlast);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_passthrough();
    int cyc, viol, bad, badl;
    for (int k = 0; k < 64; k++) wdat[k] = {16'(k), 16'(-k)};
    write_frame();
    checks++;
    if (axis.tvalid !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: tvalid=%b wr_ready=%b required 0/0", axis.tvalid, wr_ready);
    end
    @(negedge clk);
    checks++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h00000000) begin
      errors++;
      $display("FAIL first_beat: tvalid=%b tdata=%h required 1/00000000", axis.tvalid, axis.tdata);
    end
    capture(0, 64, cyc, viol);
    checks++;
    if (cyc !== 64 || viol !== 0) begin
      errors++;
      $display("FAIL pass_timing: cycles=%0d violations=%0d required 64/0", cyc, viol);
    end
    bad = 0; badl = 0;
    for (int i = 0; i < 64; i++) begin
      if (rx_data[i] !== wdat[i]) bad++;
      if (rx_last[i] !== (c_tlast_en && i == 63)) badl++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pass_data: %0d wrong beats required 0", bad);
    end
    checks++;
    if (badl !== 0) begin
      errors++;
      $display("FAIL pass_tlast: %0d wrong tlast beats required 0", badl);
    end
    checks++;
    if (rx_data[1] !== 32'h0001FFFF || rx_data[63] !== 32'h003FFFC1) begin
      errors++;
      $display("FAIL pass_spot: beat1=%h beat63=%h required 0001ffff/003fffc1", rx_data[1], rx_data[63]);
    end
    checks++;
    if (frame_done !== 1'b1 || axis.tvalid !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_pulse: done=%b tvalid=%b wr_ready=%b required 1/0/1",
               frame_done, axis.tvalid, wr_ready);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: done=%b required 0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    int cyc, viol, bad, badl;
    for (int k = 0; k < 64; k++) wdat[k] = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
    write_frame();
    @(negedge clk);
    capture(1, 64, cyc, viol);
    checks++;
    if (cyc !== 128 || viol !== 0) begin
      errors++;
      $display("FAIL bp_stall: cycles=%0d violations=%0d required 128/0", cyc, viol);
    end
    bad = 0; badl = 0;
    for (int i = 0; i < 64; i++) begin
      if (rx_data[i] !== wdat[i]) bad++;
      if (rx_last[i] !== (c_tlast_en && i == 63)) badl++;
    end
    checks++;
    if (bad !== 0 || badl !== 0) begin
      errors++;
      $display("FAIL bp_order: %0d wrong beats, %0d wrong tlast required 0/0", bad, badl);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b required 1", frame_done);
    end
  endtask

  task automatic test_boundary();
    int cyc, viol;
    for (int k = 0; k < 64; k++) wdat[k] = {16'hFFFF, 16'(k)};
    wdat[0]  = 32'h80007FFF;
    wdat[63] = 32'h7FFF8000;
    write_frame();
    @(negedge clk);
    capture(0, 64, cyc, viol);
    checks++;
    if (rx_data[0] !== 32'h80007FFF) begin
      errors++;
      $display("FAIL bound_min_max: tdata=%h required 80007fff", rx_data[0]);
    end
    checks++;
    if (rx_data[63] !== 32'h7FFF8000 || rx_data[32] !== 32'hFFFF0020) begin
      errors++;
      $display("FAIL bound_other: beat63=%h beat32=%h required 7fff8000/ffff0020", rx_data[63], rx_data[32]);
    end
    checks++;
    if (cyc !== 64 || viol !== 0) begin
      errors++;
      $display("FAIL bound_timing: cycles=%0d violations=%0d required 64/0", cyc, viol);
    end
  endtask

  task automatic test_illegal_writes();
    int cyc, viol, bad;
    for (int k = 0; k < 64; k++) wdat[k] = {16'h3000 + 16'(k), 16'h4000 + 16'(k)};
    write_frame();
    wr_en = 1'b1; wr_re = 16'hBEEF; wr_im = 16'hDEAD;
    @(negedge clk);
    capture(0, 64, cyc, viol);
    bad = 0;
    for (int i = 0; i < 64; i++) if (rx_data[i] !== wdat[i]) bad++;
    checks++;
    if (bad !== 0 || viol !== 0) begin
      errors++;
      $display("FAIL illegal_stream: %0d wrong beats, %0d violations required 0/0", bad, viol);
    end
    for (int k = 0; k < 64; k++) wdat[k] = {16'h5000 + 16'(k), 16'h6000 + 16'(k)};
    write_frame();
    @(negedge clk);
    capture(0, 64, cyc, viol);
    bad = 0;
    for (int i = 0; i < 64; i++) if (rx_data[i] !== wdat[i]) bad++;
    checks++;
    if (bad !== 0 || rx_data[0] !== 32'h50006000) begin
      errors++;
      $display("FAIL illegal_next_frame: %0d wrong beats, beat0=%h required 0/50006000", bad, rx_data[0]);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc, viol, bad;
    for (int k = 0; k < 64; k++) wdat[k] = {16'h7000 + 16'(k), 16'h0100 + 16'(k)};
    write_frame();
    @(negedge clk);
    capture(0, 10, cyc, viol);
    checks++;
    if (n_rx !== 10 || rx_data[9] !== 32'h70090109) begin
      errors++;
      $display("FAIL mid_prefix: beats=%0d beat9=%h required 10/70090109", n_rx, rx_data[9]);
    end
    resetn = 1'b0;
    axis.tready = 1'b0;
    @(negedge clk);
    checks++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 32'h0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tvalid=%b tdata=%h wr_ready=%b required 0/00000000/0",
               axis.tvalid, axis.tdata, wr_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: wr_ready=%b required 1", wr_ready);
    end
    for (int k = 0; k < 64; k++) wdat[k] = {16'h0A00 + 16'(k), ~16'(k)};
    write_frame();
    @(negedge clk);
    capture(0, 64, cyc, viol);
    bad = 0;
    for (int i = 0; i < 64; i++) if (rx_data[i] !== wdat[i]) bad++;
    checks++;
    if (bad !== 0 || viol !== 0 || rx_data[0] !== 32'h0A00FFFF) begin
      errors++;
      $display("FAIL mid_refill: %0d wrong beats, %0d violations, beat0=%h required 0/0/0a00ffff",
               bad, viol, rx_data[0]);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_done: done=%b required 1", frame_done);
    end
  endtask

  // Scenario sequence
  initial begin
    resetn      = 1'b0;
    wr_en       = 1'b0;
    wr_re       = '0;
    wr_im       = '0;
    axis.tready = 1'b0;
    test_reset();
    test_passthrough();
    test_backpressure();
    test_boundary();
    test_illegal_writes();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_k_cplx_sample_tx
`default_nettype wire
